axil_sram_bridge: RTL and testbench

AXI4-Lite slave front end that converts register-bus transactions into native accesses on the two-port SRAM (`sram_mem_ab`). Read channel (AR/R) drives SRAM port A; write channel (AW/W/B) drives SRAM port B with WSTRB as the byte mask. The two channels run independently, with one outstanding transaction each. Instantiated next to `sram_mem_ab` inside the `axil_2p_sram` top.

---
 rtl/axil_sram_pkg.sv | 32 +++
 rtl/axil_sram_bridge_if.sv | 51 +++++
 rtl/axil_sram_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_axil_sram_bridge.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_sram_pkg
// Purpose  : Shared types and constants for the AXI4-Lite to SRAM bridge.
//            Holds the write/read FSM state encodings and the AXI response
//            codes used by axil_sram_bridge.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axil_sram_pkg;

    // Write channel FSM: capture AW/W, pulse the SRAM write, return B.
    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_ISSUE = 2'd1,
        WR_RESP  = 2'd2
    } wr_state_e;

    // Read channel FSM: capture AR, pulse the SRAM read, wait, return R.
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        RD_RESP  = 2'd3
    } rd_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    // Reserved for a future error path; the bridge never returns it today.
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axil_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_sram_bridge_if
// Purpose  : AXI4-Lite bus bundle (AW, W, B, AR, R channels) between a
//            register-bus master and the axil_sram_bridge slave.
// Ports    : none; signals are reached through the modports
//            master : drives AW/W/AR payload+valid and B/R ready
//            slave  : drives AW/W/AR ready and B/R payload+valid
// Revision : 1.0 - initial release
// ============================================================================
interface axil_sram_bridge_if #(
    parameter int AXI_ADDR_W = 8,
    parameter int DATA_W     = 32,
    parameter int BYTE_W     = DATA_W / 8
);
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_W-1:0]     wdata;
    logic [BYTE_W-1:0]     wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface
`default_nettype wire

// File: rtl/axil_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axil_sram_bridge
// Purpose  : AXI4-Lite slave that turns register-bus reads into SRAM port A
//            reads and register-bus writes into SRAM port B masked writes.
//            Read and write channels are independent, one outstanding
//            transaction each. Every output is registered.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            s_axil          - AXI4-Lite slave bundle (axil_sram_bridge_if)
//            a_en/a_re/a_addr - SRAM read request (port A)
//            a_rdata/a_rvalid - SRAM read return, one cycle after request
//            b_en/b_we/b_addr/b_wdata/b_wmask - SRAM masked write (port B)
// Revision : 1.0 - initial release
// ============================================================================
module axil_sram_bridge
    import axil_sram_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,      // only 32 is supported
    parameter int BYTE_W     = DATA_W / 8,
    parameter int AXI_ADDR_W = ADDR_W + 2
) (
    input  logic                clk,
    input  logic                rst,

    axil_sram_bridge_if.slave   s_axil,

    output logic                a_en,
    output logic                a_re,
    output logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_rdata,
    input  logic                a_rvalid,

    output logic                b_en,
    output logic                b_we,
    output logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_wdata,
    output logic [BYTE_W-1:0]   b_wmask
);

    localparam logic [1:0] c_WR_IDLE  = WR_IDLE;
    localparam logic [1:0] c_WR_ISSUE = WR_ISSUE;
    localparam logic [1:0] c_WR_RESP  = WR_RESP;

    localparam logic [1:0] c_RD_IDLE  = RD_IDLE;
    localparam logic [1:0] c_RD_ISSUE = RD_ISSUE;
    localparam logic [1:0] c_RD_WAIT  = RD_WAIT;
    localparam logic [1:0] c_RD_RESP  = RD_RESP;

    // Byte-offset bits carry no meaning for word accesses.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]        r_wr_state;
    logic              r_aw_done;
    logic              r_w_done;
    logic [ADDR_W-1:0] r_aw_addr;
    logic [DATA_W-1:0] r_w_data;
    logic [BYTE_W-1:0] r_w_strb;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic              r_b_en;
    logic [ADDR_W-1:0] r_b_addr;
    logic [DATA_W-1:0] r_b_wdata;
    logic [BYTE_W-1:0] r_b_wmask;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_aw_have;
    logic              w_w_have;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [BYTE_W-1:0] w_wr_strb;

    assign w_aw_hs   = s_axil.awvalid & r_awready;
    assign w_w_hs    = s_axil.wvalid  & r_wready;
    assign w_aw_have = r_aw_done | w_aw_hs;
    assign w_w_have  = r_w_done  | w_w_hs;

    // When the second half of the pair arrives this edge, take it straight
    // from the bus so the SRAM write issues in the very next cycle.
    assign w_wr_addr = r_aw_done ? r_aw_addr : s_axil.awaddr[AXI_ADDR_W-1:2];
    assign w_wr_data = r_w_done  ? r_w_data  : s_axil.wdata;
    assign w_wr_strb = r_w_done  ? r_w_strb  : s_axil.wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= c_WR_IDLE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_aw_addr  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_b_en     <= 1'b0;
            r_b_addr   <= '0;
            r_b_wdata  <= '0;
            r_b_wmask  <= '0;
        end else begin
            case (r_wr_state)
                c_WR_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                        r_aw_addr <= s_axil.awaddr[AXI_ADDR_W-1:2];
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                        r_w_data <= s_axil.wdata;
                        r_w_strb <= s_axil.wstrb;
                    end
                    if (w_aw_have && w_w_have) begin
                        r_wr_state <= c_WR_ISSUE;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                        r_b_en     <= 1'b1;
                        r_b_addr   <= w_wr_addr;
                        r_b_wdata  <= w_wr_data;
                        r_b_wmask  <= w_wr_strb;
                    end else begin
                        // Each ready stays up only until its own beat lands.
                        r_awready <= ~w_aw_have;
                        r_wready  <= ~w_w_have;
                    end
                end
                c_WR_ISSUE: begin
                    r_wr_state <= c_WR_RESP;
                    r_b_en     <= 1'b0;
                    r_b_addr   <= '0;
                    r_b_wdata  <= '0;
                    r_b_wmask  <= '0;
                    r_bvalid   <= 1'b1;
                end
                c_WR_RESP: begin
                    if (s_axil.bready) begin
                        r_wr_state <= c_WR_IDLE;
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                default: begin
                    r_wr_state <= c_WR_IDLE;
                end
            endcase
        end
    end

    assign s_axil.awready = r_awready;
    assign s_axil.wready  = r_wready;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = AXI_RESP_OKAY;

    assign b_en    = r_b_en;
    assign b_we    = r_b_en;
    assign b_addr  = r_b_addr;
    assign b_wdata = r_b_wdata;
    assign b_wmask = r_b_wmask;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [1:0]        r_rd_state;
    logic              r_arready;
    logic              r_a_en;
    logic [ADDR_W-1:0] r_a_addr;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= c_RD_IDLE;
            r_arready  <= 1'b0;
            r_a_en     <= 1'b0;
            r_a_addr   <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                c_RD_IDLE: begin
                    if (s_axil.arvalid && r_arready) begin
                        // The issue register doubles as the address capture.
                        r_rd_state <= c_RD_ISSUE;
                        r_arready  <= 1'b0;
                        r_a_en     <= 1'b1;
                        r_a_addr   <= s_axil.araddr[AXI_ADDR_W-1:2];
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                c_RD_ISSUE: begin
                    r_rd_state <= c_RD_WAIT;
                    r_a_en     <= 1'b0;
                    r_a_addr   <= '0;
                end
                c_RD_WAIT: begin
                    // Only a return seen here belongs to our request.
                    if (a_rvalid) begin
                        r_rd_state <= c_RD_RESP;
                        r_rdata    <= a_rdata;
                        r_rvalid   <= 1'b1;
                    end
                end
                c_RD_RESP: begin
                    if (s_axil.rready) begin
                        r_rd_state <= c_RD_IDLE;
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                    end
                end
                default: begin
                    r_rd_state <= c_RD_IDLE;
                end
            endcase
        end
    end

    assign s_axil.arready = r_arready;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = AXI_RESP_OKAY;

    assign a_en   = r_a_en;
    assign a_re   = r_a_en;
    assign a_addr = r_a_addr;

endmodule
`default_nettype wire

// File: tb/tb_axil_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_sram_bridge
// Purpose  : Directed self-checking bench for axil_sram_bridge with a
//            behavioural two-port SRAM (WRITE_FIRST on same-word conflict).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axil_sram_bridge;
    import axil_sram_pkg::*;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 32;
    localparam int BYTE_W     = 4;
    localparam int AXI_ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_sram_bridge_if #(.AXI_ADDR_W(AXI_ADDR_W), .DATA_W(DATA_W), .BYTE_W(BYTE_W)) axil();

    logic              a_en, a_re;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_rdata  = '0;
    logic              a_rvalid = 1'b0;
    logic              b_en, b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [BYTE_W-1:0] b_wmask;

    axil_sram_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTE_W(BYTE_W), .AXI_ADDR_W(AXI_ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .s_axil(axil),
        .a_en(a_en), .a_re(a_re), .a_addr(a_addr), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask)
    );

    // Behavioural SRAM: one-cycle read return, same-word conflict returns new data.
    logic [DATA_W-1:0] mem [0:63] = '{default: '0};

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = m[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return res;
    endfunction

    always @(posedge clk) begin
        if (a_en && a_re) begin
            a_rvalid <= 1'b1;
            a_rdata  <= (b_en && b_we && b_addr == a_addr) ? merge(mem[a_addr], b_wdata, b_wmask)
                                                           : mem[a_addr];
        end else begin
            a_rvalid <= 1'b0;
        end
        if (b_en && b_we) mem[b_addr] <= merge(mem[b_addr], b_wdata, b_wmask);
    end

    int a_en_cnt = 0;
    int b_en_cnt = 0;
    always @(posedge clk) begin
        if (a_en) a_en_cnt <= a_en_cnt + 1;
        if (b_en) b_en_cnt <= b_en_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_pend, w_pend, aw_fire, w_fire, b_fire;
        int n;
        aw_pend = 1'b1; w_pend = 1'b1; b_fire = 1'b0; n = 0;
        axil.awaddr = addr; axil.awvalid = 1'b1;
        axil.wdata = data; axil.wstrb = strb; axil.wvalid = 1'b1;
        axil.bready = 1'b1;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_fire = aw_pend && axil.awready;
            w_fire  = w_pend && axil.wready;
            tick(); n++;
            if (aw_fire) begin aw_pend = 1'b0; axil.awvalid = 1'b0; end
            if (w_fire)  begin w_pend = 1'b0;  axil.wvalid = 1'b0;  end
        end
        while (!b_fire && n < 40) begin
            b_fire = axil.bvalid;
            tick(); n++;
        end
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.bready = 1'b0;
        checks++;
        if (aw_pend || w_pend || !b_fire) begin
            errors++;
            $display("FAIL wr_timeout addr=%0h: done=%0b required 1", addr, !(aw_pend || w_pend) && b_fire);
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
        bit ar_pend, ar_fire, r_fire;
        int n;
        ar_pend = 1'b1; r_fire = 1'b0; n = 0; data = '0;
        axil.araddr = addr; axil.arvalid = 1'b1; axil.rready = 1'b1;
        while (ar_pend && n < 20) begin
            ar_fire = axil.arready;
            tick(); n++;
            if (ar_fire) begin ar_pend = 1'b0; axil.arvalid = 1'b0; end
        end
        while (!r_fire && n < 40) begin
            r_fire = axil.rvalid;
            data   = axil.rdata;
            tick(); n++;
        end
        axil.arvalid = 1'b0; axil.rready = 1'b0;
        checks++;
        if (ar_pend || !r_fire) begin
            errors++;
            $display("FAIL rd_timeout addr=%0h: done=%0b required 1", addr, !ar_pend && r_fire);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid,
             a_en, a_re, b_en, b_we} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000000", {axil.awready, axil.wready,
                     axil.arready, axil.bvalid, axil.rvalid, a_en, a_re, b_en, b_we});
        end
        checks++;
        if ({axil.bresp, axil.rresp, axil.rdata, a_addr, b_addr, b_wdata, b_wmask} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0",
                     {axil.bresp, axil.rresp, axil.rdata, a_addr, b_addr, b_wdata, b_wmask});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({axil.awready, axil.wready, axil.arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got %b required 111", {axil.awready, axil.wready, axil.arready});
        end
    endtask

    task automatic test_write_read();
        axil.awaddr = 8'h10; axil.awvalid = 1'b1;
        axil.wdata = 32'hDEADBEEF; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        axil.bready = 1'b0;
        tick();                                   // AW+W handshake edge
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        checks++;
        if ({axil.awready, axil.wready, axil.bvalid, b_en, b_we} !== 5'b00011) begin
            errors++;
            $display("FAIL wr_issue_ctrl: got %b required 00011",
                     {axil.awready, axil.wready, axil.bvalid, b_en, b_we});
        end
        checks++;
        if ({b_addr, b_wmask, b_wdata} !== {6'd4, 4'hF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL wr_issue_data: got addr=%0d mask=%h data=%h required 4 f deadbeef",
                     b_addr, b_wmask, b_wdata);
        end
        tick();
        checks++;
        if ({axil.bvalid, axil.bresp, b_en, b_addr} !== {1'b1, AXI_RESP_OKAY, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL wr_bresp: got bvalid=%b bresp=%b b_en=%b b_addr=%0d required 1 00 0 0",
                     axil.bvalid, axil.bresp, b_en, b_addr);
        end
        axil.bready = 1'b1;
        tick();
        axil.bready = 1'b0;
        checks++;
        if ({axil.bvalid, axil.awready, axil.wready} !== 3'b011) begin
            errors++;
            $display("FAIL wr_done: got %b required 011", {axil.bvalid, axil.awready, axil.wready});
        end

        axil.araddr = 8'h10; axil.arvalid = 1'b1; axil.rready = 1'b0;
        tick();                                   // AR handshake edge
        axil.arvalid = 1'b0;
        checks++;
        if ({a_en, a_re, axil.arready, a_addr} !== {3'b110, 6'd4}) begin
            errors++;
            $display("FAIL rd_issue: got en=%b re=%b arready=%b addr=%0d required 1 1 0 4",
                     a_en, a_re, axil.arready, a_addr);
        end
        tick();
        checks++;
        if ({a_en, axil.rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rd_wait: got a_en=%b rvalid=%b required 0 0", a_en, axil.rvalid);
        end
        tick();
        checks++;
        if ({axil.rvalid, axil.rresp, axil.rdata} !== {1'b1, AXI_RESP_OKAY, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL rd_resp: got rvalid=%b rresp=%b rdata=%h required 1 00 deadbeef",
                     axil.rvalid, axil.rresp, axil.rdata);
        end
        axil.rready = 1'b1;
        tick();
        axil.rready = 1'b0;
        checks++;
        if ({axil.rvalid, axil.arready} !== 2'b01) begin
            errors++;
            $display("FAIL rd_done: got %b required 01", {axil.rvalid, axil.arready});
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        axi_write(8'h10, 32'h11223344, 4'b0101);
        axi_read(8'h10, d);
        checks++;
        if (d !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL strobe_merge: got %h required de22be44", d);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] d;
        bit got;
        int n;
        axil.awaddr = 8'h20; axil.awvalid = 1'b1;
        axil.wdata = 32'hA5A5A5A5; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        axil.araddr = 8'h20; axil.arvalid = 1'b1;
        axil.bready = 1'b1; axil.rready = 1'b1;
        tick();
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
        checks++;
        if ({a_en, b_en, a_addr, b_addr} !== {2'b11, 6'd8, 6'd8}) begin
            errors++;
            $display("FAIL conflict_issue: got a_en=%b b_en=%b a_addr=%0d b_addr=%0d required 1 1 8 8",
                     a_en, b_en, a_addr, b_addr);
        end
        got = 1'b0; n = 0; d = '0;
        while (!got && n < 10) begin
            if (axil.rvalid) begin got = 1'b1; d = axil.rdata; end
            tick(); n++;
        end
        axil.bready = 1'b0; axil.rready = 1'b0;
        checks++;
        if (!got || d !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL conflict_rdata: got valid=%b data=%h required 1 a5a5a5a5", got, d);
        end
        tick();
        checks++;
        if ({axil.awready, axil.wready, axil.arready, axil.bvalid} !== 4'b1110) begin
            errors++;
            $display("FAIL conflict_idle: got %b required 1110",
                     {axil.awready, axil.wready, axil.arready, axil.bvalid});
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        int b0;
        b0 = b_en_cnt;
        axil.wdata = 32'hCAFEF00D; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        axil.awvalid = 1'b0; axil.bready = 1'b0;
        tick();                                   // W captured
        axil.wvalid = 1'b0;
        checks++;
        if ({axil.wready, axil.awready, b_en} !== 3'b010) begin
            errors++;
            $display("FAIL wfirst_capture: got wready=%b awready=%b b_en=%b required 0 1 0",
                     axil.wready, axil.awready, b_en);
        end
        tick(); tick();
        axil.awaddr = 8'h20; axil.awvalid = 1'b1;
        tick();                                   // AW handshake, 3 cycles after W
        axil.awvalid = 1'b0;
        checks++;
        if ({b_en, b_addr, b_wdata} !== {1'b1, 6'd8, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL wfirst_issue: got b_en=%b addr=%0d data=%h required 1 8 cafef00d",
                     b_en, b_addr, b_wdata);
        end
        tick();
        checks++;
        if ({b_en, axil.bvalid} !== 2'b01) begin
            errors++;
            $display("FAIL wfirst_resp: got b_en=%b bvalid=%b required 0 1", b_en, axil.bvalid);
        end
        axil.bready = 1'b1;
        tick();
        axil.bready = 1'b0;
        checks++;
        if (b_en_cnt - b0 !== 1) begin
            errors++;
            $display("FAIL wfirst_pulses: got %0d required 1", b_en_cnt - b0);
        end
        axi_read(8'h20, d);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wfirst_readback: got %h required cafef00d", d);
        end
    endtask

    task automatic test_backpressure();
        int a0, n;
        a0 = a_en_cnt; n = 0;
        axil.araddr = 8'h20; axil.arvalid = 1'b1; axil.rready = 1'b0;
        tick();
        axil.arvalid = 1'b0;
        while (axil.rvalid !== 1'b1 && n < 10) begin tick(); n++; end
        checks++;
        if (axil.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout: got rvalid=%b required 1", axil.rvalid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({axil.rvalid, axil.arready, axil.rdata} !== {2'b10, 32'hCAFEF00D}) begin
                errors++;
                $display("FAIL bp_hold%0d: got rvalid=%b arready=%b rdata=%h required 1 0 cafef00d",
                         i, axil.rvalid, axil.arready, axil.rdata);
            end
        end
        axil.rready = 1'b1;
        tick();
        axil.rready = 1'b0;
        checks++;
        if ({axil.rvalid, axil.arready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got %b required 01", {axil.rvalid, axil.arready});
        end
        checks++;
        if (a_en_cnt - a0 !== 1) begin
            errors++;
            $display("FAIL bp_pulses: got %0d required 1", a_en_cnt - a0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        axil.awaddr = 8'h30; axil.awvalid = 1'b1;
        axil.wdata = 32'h12345678; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        axil.araddr = 8'h30; axil.arvalid = 1'b1;
        axil.bready = 1'b0; axil.rready = 1'b0;
        tick();                                   // both issue next cycle
        axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
        tick();                                   // WR_RESP and RD_WAIT
        checks++;
        if ({axil.bvalid, axil.rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_pre: got bvalid=%b rvalid=%b required 1 0", axil.bvalid, axil.rvalid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({axil.bvalid, axil.rvalid, a_en, b_en, axil.awready, axil.wready, axil.arready} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got %b required 0000000", {axil.bvalid, axil.rvalid,
                     a_en, b_en, axil.awready, axil.wready, axil.arready});
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL rstmid_ready: got %b required 11100",
                     {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid});
        end
        tick();
        checks++;
        if (axil.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_norvalid: got %b required 0", axil.rvalid);
        end
        axi_read(8'h30, d);
        checks++;
        if (d !== 32'h12345678) begin
            errors++;
            $display("FAIL rstmid_readback: got %h required 12345678", d);
        end
    endtask

    initial begin
        axil.awaddr = '0; axil.awvalid = 1'b0;
        axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
        axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
        test_reset();
        test_write_read();
        test_strobe();
        test_conflict();
        test_w_before_aw();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
